// File: rtl/oled_ctrl.sv
// SSD1306 sequencer: power-up wait, init LUT, optional RAM clear, then
// display arbitration of the shared I2C writer. OLED_CLEAR_EN enables CLEAR.
module oled_ctrl #(
    parameter int unsigned PWR_DLY  = 5000000,
    parameter logic [7:0]  CLR_FILL = 8'h00,
    parameter int unsigned COLS     = 128,
    parameter int unsigned PAGES    = 8
) (
    input  logic        clk_50m,
    input  logic        rst,
    output logic        o_init_req,
    input  logic [23:0] i_init_data,
    input  logic        i_init_done,
    input  logic        i_disp_req,
    input  logic [23:0] i_disp_data,
    output logic        o_disp_ack,
    input  logic        i_reinit,
    output logic        o_wr_req,
    output logic [23:0] o_wr_data,
    input  logic        i_wr_done,
    output logic        o_ready
);

    localparam int DLY_W = (PWR_DLY > 0) ? $clog2(PWR_DLY + 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST =
        DLY_W'((PWR_DLY > 0) ? PWR_DLY - 1 : 0);

    typedef enum logic [1:0] {
        PWR,
        INIT,
        CLEAR,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [DLY_W-1:0] dly_cnt;
    logic             reinit_q;
    logic             reinit_pend;

    // A pulse arriving while already in RUN acts without waiting a cycle.
    assign reinit_pend = reinit_q | i_reinit;

`ifdef OLED_CLEAR_EN
    localparam logic [7:0] STEP_LAST = 8'(COLS + 2);
    localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

    logic [7:0]  step;
    logic [2:0]  page;
    logic        clr_wrap;
    logic        clr_end;
    logic [23:0] clr_data;

    assign clr_wrap = (step == STEP_LAST);
    assign clr_end  = clr_wrap && (page == PAGE_LAST);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            step <= '0;
            page <= '0;
        end else if (state_nx == INIT) begin
            step <= '0;
            page <= '0;
        end else if (state == CLEAR && i_wr_done && !clr_end) begin
            if (clr_wrap) begin
                step <= '0;
                page <= page + 3'd1;
            end else begin
                step <= step + 8'd1;
            end
        end
    end

    // Page header: page address, column low nibble, column high nibble.
    always_comb begin
        clr_data = {16'h7840, CLR_FILL};
        if (step == 8'd0)
            clr_data = {16'h7800, 5'b10110, page};
        else if (step == 8'd1)
            clr_data = 24'h780000;
        else if (step == 8'd2)
            clr_data = 24'h780010;
    end
`endif

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state    <= PWR;
            dly_cnt  <= '0;
            reinit_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == PWR && state_nx == PWR)
                dly_cnt <= dly_cnt + 1'b1;
            if (state == RUN && state_nx == INIT)
                reinit_q <= 1'b0;
            else if (state != PWR && i_reinit)
                reinit_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        o_init_req = 1'b0;
        o_wr_req   = 1'b0;
        o_wr_data  = '0;
        o_disp_ack = 1'b0;
        o_ready    = 1'b0;
        unique case (state)
            PWR: begin
                if (PWR_DLY == 0 || dly_cnt == DLY_LAST)
                    state_nx = INIT;
            end
            INIT: begin
                o_init_req = 1'b1;
                o_wr_req   = 1'b1;
                o_wr_data  = i_init_data;
`ifdef OLED_CLEAR_EN
                if (i_init_done)
                    state_nx = CLEAR;
`else
                if (i_init_done)
                    state_nx = RUN;
`endif
            end
`ifdef OLED_CLEAR_EN
            CLEAR: begin
                o_wr_req  = 1'b1;
                o_wr_data = clr_data;
                if (i_wr_done && clr_end)
                    state_nx = RUN;
            end
`endif
            RUN: begin
                o_ready    = 1'b1;
                o_wr_req   = i_disp_req;
                o_wr_data  = i_disp_data;
                o_disp_ack = i_wr_done & i_disp_req;
                // An in-flight display write finishes before re-init.
                if (reinit_pend && (!i_disp_req || i_wr_done))
                    state_nx = INIT;
            end
            default: state_nx = PWR;
        endcase
    end

endmodule

// File: tb/tb_oled_ctrl.sv
// Scoreboard bench for oled_ctrl: I2C engine, init LUT and display
// requester models drive the DUT; a negedge monitor checks every write.
module tb_oled_ctrl;

    localparam int PWR_DLY = 10;
`ifdef OLED_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] d;
        logic        disp;
        logic        init;
        logic        last;
    } exp_t;

    logic        clk_50m;
    logic        rst;
    logic        o_init_req;
    logic [23:0] i_init_data;
    logic        i_init_done;
    logic        i_disp_req;
    logic [23:0] i_disp_data;
    logic        o_disp_ack;
    logic        i_reinit;
    logic        o_wr_req;
    logic [23:0] o_wr_data;
    logic        i_wr_done;
    logic        o_ready;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          req_budget = 0;

    oled_ctrl #(.PWR_DLY(PWR_DLY)) dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .o_init_req (o_init_req),
        .i_init_data(i_init_data),
        .i_init_done(i_init_done),
        .i_disp_req (i_disp_req),
        .i_disp_data(i_disp_data),
        .o_disp_ack (o_disp_ack),
        .i_reinit   (i_reinit),
        .o_wr_req   (o_wr_req),
        .o_wr_data  (o_wr_data),
        .i_wr_done  (i_wr_done),
        .o_ready    (o_ready)
    );

    initial begin
        clk_50m = 1'b0;
        forever #5 clk_50m = ~clk_50m;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] lut(int i);
        if (i == 0)
            return 24'h7800AE;
        return {16'h7800, 8'(8'h20 + 3 * i)};
    endfunction

    // Reference sequence: 27 init words, then 8 pages of header + columns.
    task automatic push_seq();
        exp_t e;
        for (int i = 0; i < 27; i++) begin
            e.d = lut(i);
            e.disp = 1'b0;
            e.init = 1'b1;
            e.last = !CLR && i == 26;
            sb.push_back(e);
        end
        if (CLR) begin
            for (int p = 0; p < 8; p++) begin
                for (int s = 0; s < 131; s++) begin
                    if (s == 0)
                        e.d = 24'h7800B0 + 24'(p);
                    else if (s == 1)
                        e.d = 24'h780000;
                    else if (s == 2)
                        e.d = 24'h780010;
                    else
                        e.d = 24'h784000;
                    e.disp = 1'b0;
                    e.init = 1'b0;
                    e.last = p == 7 && s == 130;
                    sb.push_back(e);
                end
            end
        end
    endtask

    // I2C engine, init LUT and display requester on one timeline.
    initial begin
        int  idx;
        int  lat;
        int  gap;
        bit  busy;
        bit  adv;
        bit  ack_seen;
        exp_t e;
        idx = 0; lat = 0; gap = 0;
        busy = 0; adv = 0; ack_seen = 0;
        i_wr_done = 0;
        i_init_done = 0;
        i_disp_req = 0;
        i_disp_data = '0;
        i_init_data = lut(0);
        forever begin
            @(posedge clk_50m);
            #1;
            i_wr_done = 0;
            i_init_done = 0;
            if (rst) begin
                busy = 0; adv = 0; ack_seen = 0; gap = 0;
                idx = 0;
                i_disp_req = 0;
            end else begin
                if (adv) idx++;
                adv = 0;
                if (!o_init_req) idx = 0;
                if (ack_seen) begin
                    i_disp_req = 0;
                    ack_seen = 0;
                    gap = $urandom_range(0, 3);
                end else if (gap > 0) begin
                    gap--;
                end else if (!i_disp_req && req_budget > 0) begin
                    i_disp_data = 24'($urandom);
                    i_disp_req = 1;
                    req_budget--;
                    e.d = i_disp_data;
                    e.disp = 1'b1;
                    e.init = 1'b0;
                    e.last = 1'b0;
                    sb.push_back(e);
                end
            end
            i_init_data = lut(idx);
            #1;
            if (!rst) begin
                if (!busy && o_wr_req) begin
                    busy = 1;
                    lat = $urandom_range(0, 3);
                end
                if (busy) begin
                    if (lat == 0) begin
                        busy = 0;
                        i_wr_done = 1;
                        if (o_init_req) begin
                            i_init_done = (idx == 26);
                            adv = 1;
                        end
                        #1 ack_seen = o_disp_ack;
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    // Monitor: pops one expected word per completed write.
    logic [23:0] cap;
    bit          cap_valid = 0;
    bit          ready_chk = 0;
    always @(negedge clk_50m) begin
        exp_t e;
        if (rst) begin
            cap_valid = 0;
            ready_chk = 0;
        end else begin
            if (ready_chk) begin
                chk("ready_after_seq", 32'(o_ready), 1);
                ready_chk = 0;
            end
            if (o_wr_req && !cap_valid) begin
                cap = o_wr_data;
                cap_valid = 1;
            end
            if (i_wr_done && o_wr_req) begin
                chk("write_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_data", 32'(o_wr_data), 32'(e.d));
                    chk("wr_data_held", 32'(cap), 32'(e.d));
                    chk("disp_ack", 32'(o_disp_ack), 32'(e.disp));
                    chk("init_req", 32'(o_init_req), 32'(e.init));
                    chk("ready", 32'(o_ready), 32'(e.disp));
                    if (e.last) ready_chk = 1;
                end
                cap_valid = 0;
            end else if (o_disp_ack) begin
                chk("spurious_ack", 32'(o_disp_ack), 0);
            end
            if (!o_wr_req) cap_valid = 0;
        end
    end

    task automatic check_idle(string nm);
        chk({nm, "_wr_req"}, 32'(o_wr_req), 0);
        chk({nm, "_wr_data"}, 32'(o_wr_data), 0);
        chk({nm, "_init_req"}, 32'(o_init_req), 0);
        chk({nm, "_disp_ack"}, 32'(o_disp_ack), 0);
        chk({nm, "_ready"}, 32'(o_ready), 0);
    endtask

    // Called on the negedge where rst drops; optional reinit pulse in PWR.
    task automatic measure_pwr(bit drop);
        int low = 0;
        while (!o_wr_req && low < 100) begin
            i_reinit = drop && low == 3;
            low++;
            @(negedge clk_50m);
        end
        i_reinit = 0;
        chk("pwr_wait", 32'(low), PWR_DLY);
        chk("first_word", 32'(o_wr_data), 32'h7800AE);
    endtask

    task automatic wait_drain(string nm);
        int n = 0;
        while (!(sb.size() == 0 && req_budget == 0 && !i_disp_req
                 && o_ready) && n < 20000) begin
            @(negedge clk_50m);
            n++;
        end
        chk(nm, 32'(n < 20000), 1);
    endtask

    task automatic pulse_reinit();
        i_reinit = 1;
        @(negedge clk_50m);
        i_reinit = 0;
    endtask

    task automatic wait_init(string nm);
        int n = 0;
        while (!o_init_req && n < 8) begin
            @(negedge clk_50m);
            n++;
        end
        chk(nm, 32'(o_init_req), 1);
        chk({nm, "_ready_low"}, 32'(o_ready), 0);
    endtask

    initial begin
        int n;
        rst = 1;
        i_reinit = 0;
        repeat (3) @(negedge clk_50m);
        check_idle("reset");
        push_seq();
        req_budget = 1;
        rst = 0;
        measure_pwr(1'b1);

        repeat (8) @(negedge clk_50m);
        push_seq();
        pulse_reinit();
        wait_drain("drain_initial");

        req_budget = 20;
        wait_drain("drain_disp");

        req_budget = 1;
        n = 0;
        while (!i_disp_req && n < 20) begin
            @(negedge clk_50m);
            n++;
        end
        chk("disp_req_seen", 32'(i_disp_req), 1);
        push_seq();
        pulse_reinit();
        wait_init("reinit_inflight");
        wait_drain("drain_reinit_inflight");

        push_seq();
        pulse_reinit();
        wait_init("reinit_idle");
        wait_drain("drain_reinit_idle");

        push_seq();
        pulse_reinit();
        n = 0;
        while (!(sb.size() <= (CLR ? 600 : 14) && o_wr_req) && n < 20000) begin
            @(negedge clk_50m);
            n++;
        end
        chk("reached_mid_seq", 32'(n < 20000), 1);
        #2 rst = 1;
        #1 check_idle("async_rst");
        sb.delete();
        repeat (3) @(negedge clk_50m);
        push_seq();
        rst = 0;
        measure_pwr(1'b0);
        wait_drain("drain_after_rst");

        chk("queue_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
